// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
//   Monitors a PWM waveform. For every full period it reports the high time,
//   the period length (both in clk cycles) and floor(high*100/period).
//   pwm_in is synchronised internally. The percentage comes from a 7-step
//   restoring divider.
//
// Ports
//   clk        in   1      system clock, posedge
//   rst        in   1      asynchronous, active-high reset
//   enable     in   1      1 = measure; 0 = abort and re-arm (outputs hold)
//   pwm_in     in   1      PWM input, asynchronous to clk
//   high_cnt   out  CNT_W  high cycles in the last measured period
//   period_cnt out  CNT_W  cycles between the last two rising edges
//   duty_pct   out  7      floor(high_cnt*100/period_cnt)
//   meas_valid out  1      1-cycle pulse, the three results just updated
//   overrun    out  1      1-cycle pulse, a capture was dropped (divider busy)
//   ovf        out  1      sticky counter saturation, cleared by meas_valid
module pwm_duty_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             meas_valid,
  output logic             overrun,
  output logic             ovf
);

  localparam int NUM_W = CNT_W + 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s, rise;
  logic [CNT_W-1:0]       per_acc_q, per_acc_d, hi_acc_q, hi_acc_d;
  logic [NUM_W-1:0]       rem_q, rem_d, dsh_q, dsh_d;
  logic [6:0]             quo_q, quo_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [CNT_W-1:0]       div_hi_q, div_hi_d, div_per_q, div_per_d;
  logic [CNT_W-1:0]       res_hi_q, res_hi_d, res_per_q, res_per_d;
  logic [6:0]             res_pct_q, res_pct_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
  logic [6:0]             duty_pct_q, duty_pct_d;
  logic                   meas_valid_q, meas_valid_d, overrun_q, overrun_d;
  logic                   ovf_q, ovf_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  always_comb begin
    state_d      = state_q;
    per_acc_d    = per_acc_q;
    hi_acc_d     = hi_acc_q;
    rem_d        = rem_q;
    dsh_d        = dsh_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    div_hi_d     = div_hi_q;
    div_per_d    = div_per_q;
    res_hi_d     = res_hi_q;
    res_per_d    = res_per_q;
    res_pct_d    = res_pct_q;
    done_d       = 1'b0;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    duty_pct_d   = duty_pct_q;
    meas_valid_d = 1'b0;
    overrun_d    = 1'b0;
    ovf_d        = ovf_q;

    if (!enable) begin
      state_d   = IDLE;
      per_acc_d = '0;
      hi_acc_d  = '0;
      cnt_d     = '0;
    end else begin
      // Restoring division against the divisor pre-shifted by 6. The quotient
      // never exceeds 100 because hi <= per, so 7 quotient bits are enough.
      if (cnt_q != 3'd0) begin
        if (rem_q >= dsh_q) begin
          rem_d = rem_q - dsh_q;
          quo_d = {quo_q[5:0], 1'b1};
        end else begin
          quo_d = {quo_q[5:0], 1'b0};
        end
        dsh_d = dsh_q >> 1;
        cnt_d = cnt_q - 3'd1;
        // The result is staged on the last step, so a capture in this same
        // cycle can reload the working registers without losing it.
        if (cnt_q == 3'd1) begin
          res_pct_d = quo_d;
          res_hi_d  = div_hi_q;
          res_per_d = div_per_q;
          done_d    = 1'b1;
        end
      end

      if (done_q) begin
        high_cnt_d   = res_hi_q;
        period_cnt_d = res_per_q;
        duty_pct_d   = res_pct_q;
        meas_valid_d = 1'b1;
        ovf_d        = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d   = RUN;
            per_acc_d = CNT_W'(1);
            hi_acc_d  = CNT_W'(1);
          end
        end
        RUN: begin
          if (rise) begin
            // The rise cycle is the first high cycle of the next period.
            per_acc_d = CNT_W'(1);
            hi_acc_d  = CNT_W'(1);
            // A saturated period is meaningless and is silently discarded.
            if (per_acc_q != CNT_MAX) begin
              if (cnt_q > 3'd1) begin
                overrun_d = 1'b1;
              end else begin
                rem_d     = NUM_W'(hi_acc_q) * NUM_W'(7'd100);
                dsh_d     = {1'b0, per_acc_q, 6'b0};
                quo_d     = '0;
                cnt_d     = 3'd7;
                div_hi_d  = hi_acc_q;
                div_per_d = per_acc_q;
              end
            end
          end else begin
            if (per_acc_q == CNT_MAX) ovf_d = 1'b1;
            else                      per_acc_d = per_acc_q + CNT_W'(1);
            if (s) begin
              if (hi_acc_q == CNT_MAX) ovf_d = 1'b1;
              else                     hi_acc_d = hi_acc_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      s_d_q        <= 1'b0;
      per_acc_q    <= '0;
      hi_acc_q     <= '0;
      rem_q        <= '0;
      dsh_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      div_hi_q     <= '0;
      div_per_q    <= '0;
      res_hi_q     <= '0;
      res_per_q    <= '0;
      res_pct_q    <= '0;
      done_q       <= 1'b0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      duty_pct_q   <= '0;
      meas_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q        <= s;
      per_acc_q    <= per_acc_d;
      hi_acc_q     <= hi_acc_d;
      rem_q        <= rem_d;
      dsh_q        <= dsh_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      div_hi_q     <= div_hi_d;
      div_per_q    <= div_per_d;
      res_hi_q     <= res_hi_d;
      res_per_q    <= res_per_d;
      res_pct_q    <= res_pct_d;
      done_q       <= done_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      duty_pct_q   <= duty_pct_d;
      meas_valid_q <= meas_valid_d;
      overrun_q    <= overrun_d;
      ovf_q        <= ovf_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign duty_pct   = duty_pct_q;
  assign meas_valid = meas_valid_q;
  assign overrun    = overrun_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter (CNT_W=8, SYNC_STAGES=2).
// pwm_in set in step k is sampled at edge k. The rise is acted on at edge k+2.
// Results appear 8 edges after the closing rise.
module tb_pwm_duty_meter;
  localparam int CNT_W = 8;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic [6:0]       duty_pct;
  logic             meas_valid, overrun, ovf;

  int nvec = 0;
  int nerr = 0;
  int cyc_n = 0;
  int gen_on = 0, gen_lvl = 0, gen_hi = 1, gen_per = 2, gen_ph = 0;
  int nvalid = 0, novr = 0, first_vc = -1, last_vc = -1;
  int chk_int = 0, chk_vals = 0, exp_hi = 0, exp_per = 0, exp_pct = 0;
  int s0 = 0;

  pwm_duty_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .duty_pct(duty_pct),
    .meas_valid(meas_valid), .overrun(overrun), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    if (gen_on != 0) begin
      pwm_in = (gen_ph < gen_hi);
      gen_ph = (gen_ph + 1 >= gen_per) ? 0 : gen_ph + 1;
    end else begin
      pwm_in = (gen_lvl != 0);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (meas_valid) begin
      if (first_vc < 0) first_vc = cyc_n;
      else if (chk_int != 0) chk("vld_interval", cyc_n - last_vc, chk_int);
      last_vc = cyc_n;
      nvalid++;
      if (chk_vals != 0) begin
        chk("vld_high_cnt", high_cnt, exp_hi);
        chk("vld_period_cnt", period_cnt, exp_per);
        chk("vld_duty_pct", duty_pct, exp_pct);
      end
    end
    if (overrun) novr++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_stats();
    nvalid = 0; novr = 0; first_vc = -1; last_vc = -1;
  endtask

  task automatic start_gen(input int hi, input int per);
    gen_hi = hi; gen_per = per; gen_ph = 0; gen_on = 1;
    s0 = cyc_n + 1;
  endtask

  task automatic rearm();
    enable = 1'b0; gen_on = 0; gen_lvl = 0; chk_vals = 0; chk_int = 0;
    run(12);
    clear_stats();
  endtask

  task automatic expect_vals(input int hi, input int per, input int pct, input int intv);
    exp_hi = hi; exp_per = per; exp_pct = pct; chk_int = intv; chk_vals = 1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pwm_in = 1'b0;
    run(3);
    chk("rst_high_cnt", high_cnt, 0);
    chk("rst_period_cnt", period_cnt, 0);
    chk("rst_duty_pct", duty_pct, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    // 60% waveform, 6 high / 10 period
    rearm();
    enable = 1'b1;
    expect_vals(6, 10, 60, 10);
    start_gen(6, 10);
    run(60);
    chk("t1_first_valid", first_vc, s0 + 20);
    chk("t1_nvalid", nvalid, 4);
    chk("t1_overrun", novr, 0);
    chk("t1_ovf", ovf, 0);

    // 3 high / 7 period, truncated percentage
    rearm();
    enable = 1'b1;
    expect_vals(3, 7, 42, 7);
    start_gen(3, 7);
    run(50);
    chk("t2_first_valid", first_vc, s0 + 17);
    chk("t2_nvalid", nvalid, 5);
    chk("t2_overrun", novr, 0);

    // 2-cycle period: captures dropped while the divider is busy
    rearm();
    enable = 1'b1;
    expect_vals(1, 2, 50, 8);
    start_gen(1, 2);
    run(40);
    chk("t3_first_valid", first_vc, s0 + 12);
    chk("t3_nvalid", nvalid, 4);
    chk("t3_overrun", novr, 13);

    // stuck high saturates the counters, then 6/10 resumes
    rearm();
    enable = 1'b1;
    gen_lvl = 1;
    run(300);
    chk("t4_ovf_set", ovf, 1);
    chk("t4_no_valid", nvalid, 0);
    chk("t4_hold_high", high_cnt, 1);
    chk("t4_hold_duty", duty_pct, 50);
    expect_vals(6, 10, 60, 10);
    start_gen(6, 10);
    run(25);
    chk("t4_ovf_kept", ovf, 1);
    chk("t4_discard", nvalid, 0);
    run(15);
    chk("t4_first_valid", first_vc, s0 + 30);
    chk("t4_nvalid", nvalid, 1);
    chk("t4_ovf_clear", ovf, 0);

    // enable dropped during a divide
    rearm();
    enable = 1'b1;
    expect_vals(3, 7, 42, 7);
    start_gen(3, 7);
    run(12);
    enable = 1'b0; gen_on = 0; gen_lvl = 0;
    run(12);
    chk("t5_div_abort", nvalid, 0);
    chk("t5_hold_high", high_cnt, 6);
    chk("t5_hold_per", period_cnt, 10);
    chk("t5_hold_duty", duty_pct, 60);
    // enable dropped mid-period, generator keeps running
    rearm();
    enable = 1'b1;
    expect_vals(3, 7, 42, 7);
    start_gen(3, 7);
    run(5);
    enable = 1'b0;
    run(5);
    chk("t5_mid_abort", nvalid, 0);
    enable = 1'b1;
    run(26);
    chk("t5_first_valid", first_vc, s0 + 31);
    chk("t5_nvalid", nvalid, 1);

    // reset asserted mid-division
    rearm();
    enable = 1'b1;
    chk_vals = 0; chk_int = 0;
    start_gen(6, 10);
    run(15);
    rst = 1'b1;
    #2;
    chk("t6_high_cnt", high_cnt, 0);
    chk("t6_period_cnt", period_cnt, 0);
    chk("t6_duty_pct", duty_pct, 0);
    chk("t6_meas_valid", meas_valid, 0);
    chk("t6_ovf", ovf, 0);
    gen_on = 0; gen_lvl = 0;
    run(2);
    rst = 1'b0;
    clear_stats();
    run(20);
    chk("t6_no_stale", nvalid, 0);
    chk("t6_no_overrun", novr, 0);
    chk("t6_out_zero", high_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
